// File: rtl/addr_seq_pkg.sv
// Shared types and constants for the playback address sequencer.
package addr_seq_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

endpackage

// File: rtl/addr_step_calc.sv
// Next-address arithmetic for one playback step, with region-edge detection.
module addr_step_calc
    import addr_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned STEP_W = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] rstart,
    input  logic [ADDR_W-1:0] rend,
    input  logic [STEP_W-1:0] s,
    input  logic              dir,
    output logic [ADDR_W-1:0] next_addr,
    output logic              edge_hit
);

    logic [ADDR_W:0] a_w;
    logic [ADDR_W:0] s_w;
    logic [ADDR_W:0] sum;
    logic [ADDR_W:0] lim;

    // One extra bit so neither addr + s nor start + s can wrap.
    assign a_w = {1'b0, addr};
    assign s_w = (ADDR_W+1)'(s);
    assign sum = a_w + s_w;
    assign lim = {1'b0, rstart} + s_w;

    always_comb begin
        next_addr = addr;
        edge_hit  = 1'b0;
        if (dir == DIR_FWD) begin
            edge_hit  = (sum > {1'b0, rend});
            next_addr = edge_hit ? rstart : ADDR_W'(sum);
        end else begin
            edge_hit  = (a_w < lim);
            next_addr = edge_hit ? rend : ADDR_W'(a_w - s_w);
        end
    end

endmodule

// File: rtl/addr_seq.sv
// Playback address sequencer: steps through a loop region on each sample tick
// and hands every address to the flash reader over a req/ack handshake.
module addr_seq
    import addr_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 23,
    parameter int unsigned       STEP_W    = 4,
    parameter logic [ADDR_W-1:0] DEF_START = '0,
    parameter logic [ADDR_W-1:0] DEF_END   = ADDR_W'('h7FFFF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              play,
    input  logic              dir,
    input  logic              loop_mode,
    input  logic              restart,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [STEP_W-1:0] step,
    input  logic              ack,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              done,
    output logic              overrun,
    output logic              cfg_err
);

    state_t            state;
    logic [ADDR_W-1:0] rstart;
    logic [ADDR_W-1:0] rend;
    logic [STEP_W-1:0] s_eff;
    logic [ADDR_W-1:0] next_addr;
    logic              edge_hit;
    logic              restart_ok;

    assign s_eff      = (step == '0) ? STEP_W'(1) : step;
    assign restart_ok = (start_addr <= end_addr);
    assign req        = (state == WAIT_ACK);
    assign done       = (state == DONE);

    addr_step_calc #(
        .ADDR_W (ADDR_W),
        .STEP_W (STEP_W)
    ) u_step (
        .addr      (addr),
        .rstart    (rstart),
        .rend      (rend),
        .s         (s_eff),
        .dir       (dir),
        .next_addr (next_addr),
        .edge_hit  (edge_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            addr    <= DEF_START;
            rstart  <= DEF_START;
            rend    <= DEF_END;
            overrun <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            // Any restart pre-empts the FSM for this cycle; a rejected one only flags.
            if (restart) begin
                if (restart_ok) begin
                    rstart  <= start_addr;
                    rend    <= end_addr;
                    addr    <= (dir == DIR_FWD) ? start_addr : end_addr;
                    overrun <= 1'b0;
                    state   <= RUN;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (en && play) begin
                            state <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (en) begin
                            overrun <= 1'b1;
                        end
                        if (ack) begin
                            if (edge_hit && !loop_mode) begin
                                state <= DONE;
                            end else begin
                                addr  <= next_addr;
                                state <= RUN;
                            end
                        end
                    end
                    DONE: begin
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_addr_seq.sv
// Directed bench for addr_seq: queued expected request addresses checked by a monitor.
module tb_addr_seq;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              play;
    logic              dir;
    logic              loop_mode;
    logic              restart;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [STEP_W-1:0] step;
    logic              ack;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              done;
    logic              overrun;
    logic              cfg_err;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [ADDR_W-1:0] exp_q[$];

    addr_seq #(
        .ADDR_W    (ADDR_W),
        .STEP_W    (STEP_W),
        .DEF_START (23'h0),
        .DEF_END   (23'h7FFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .play       (play),
        .dir        (dir),
        .loop_mode  (loop_mode),
        .restart    (restart),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .step       (step),
        .ack        (ack),
        .req        (req),
        .addr       (addr),
        .done       (done),
        .overrun    (overrun),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted handshake must match the next queued address.
    always @(negedge clk) begin
        if (rst && req && ack) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_req: addr=%h, none expected", addr);
            end else begin
                logic [ADDR_W-1:0] e;
                e = exp_q.pop_front();
                if (addr !== e) begin
                    miscompares++;
                    $display("FAIL req_addr: got %h, expected %h", addr, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_restart(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e, input logic d);
        start_addr = s;
        end_addr   = e;
        dir        = d;
        restart    = 1'b1;
        cyc();
        restart    = 1'b0;
    endtask

    // One tick, expected address queued, ack after 'delay' req-high cycles.
    task automatic do_txn(input logic [ADDR_W-1:0] e, input int delay);
        int n;
        exp_q.push_back(e);
        en = 1'b1;
        cyc();
        en = 1'b0;
        n  = 0;
        while (!req && n < 8) begin
            cyc();
            n++;
        end
        if (!req) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: got req=0, expected req=1 for addr %h", e);
            void'(exp_q.pop_back());
            return;
        end
        repeat (delay) cyc();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; play = 1'b1; dir = 1'b1; loop_mode = 1'b1;
        restart = 1'b0; start_addr = '0; end_addr = '0; step = 4'd1; ack = 1'b0;
        #12;
        chk("reset_req", {31'd0, req}, 32'd0);
        chk("reset_addr", {9'd0, addr}, 32'h0);
        rst = 1'b1;
        cyc();
        chk("reset_flags", {29'd0, done, overrun, cfg_err}, 32'd0);

        // Forward loop from defaults, ack in the first req cycle.
        do_txn(23'h0, 0);
        do_txn(23'h1, 0);
        do_txn(23'h2, 0);
        chk("fwd_addr_after3", {9'd0, addr}, 32'h3);
        // step 0 behaves as 1
        step = 4'd0;
        do_txn(23'h3, 0);
        chk("step0_as_1", {9'd0, addr}, 32'h4);
        step = 4'd1;

        // Top of the default region wraps to start.
        do_restart(23'h0, 23'h7FFFF, 1'b0);
        chk("restart_rev_end", {9'd0, addr}, 32'h7FFFF);
        dir = 1'b1;
        do_txn(23'h7FFFF, 0);
        chk("fwd_wrap_to_start", {9'd0, addr}, 32'h0);

        // Reverse loop, step 4, remainder dropped at wrap.
        step = 4'd4;
        do_restart(23'h100, 23'h10F, 1'b0);
        do_txn(23'h10F, 1);
        do_txn(23'h10B, 0);
        do_txn(23'h107, 2);
        do_txn(23'h103, 0);
        chk("rev_wrap_to_end", {9'd0, addr}, 32'h10F);
        do_txn(23'h10F, 0);

        // One-shot forward, step 2.
        loop_mode = 1'b0;
        step      = 4'd2;
        do_restart(23'h0, 23'h5, 1'b1);
        do_txn(23'h0, 0);
        do_txn(23'h2, 0);
        do_txn(23'h4, 0);
        chk("oneshot_done", {31'd0, done}, 32'd1);
        chk("oneshot_hold", {9'd0, addr}, 32'h4);
        en = 1'b1;
        cyc();
        en = 1'b0;
        cyc();
        chk("done_ignores_en", {30'd0, req, done}, 32'd1);
        do_restart(23'h0, 23'h5, 1'b1);
        chk("restart_clears_done", {8'd0, done, addr}, 32'h0);

        // Overrun: ack withheld five cycles, second tick while waiting.
        loop_mode = 1'b1;
        step      = 4'd1;
        exp_q.push_back(23'h0);
        en = 1'b1;
        cyc();
        en = 1'b0;
        cyc();
        en = 1'b1;
        cyc();
        en = 1'b0;
        cyc();
        chk("wait_req_held", {8'd0, req, addr}, {8'd0, 1'b1, 23'h0});
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        cyc();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("single_advance", {8'd0, req, addr}, 32'h1);
        cyc();
        chk("no_extra_req", {31'd0, req}, 32'd0);

        // Rejected restart: flag pulses, region and addr untouched.
        do_restart(23'h20, 23'h10, 1'b1);
        chk("cfg_err_pulse", {8'd0, cfg_err, addr}, {8'd0, 1'b1, 23'h1});
        cyc();
        chk("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
        step = 4'd5;
        do_txn(23'h1, 0);
        chk("region_kept", {9'd0, addr}, 32'h0);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Restart aborts an outstanding request; late ack is ignored.
        step = 4'd1;
        en = 1'b1;
        cyc();
        en = 1'b0;
        chk("abort_req_up", {31'd0, req}, 32'd1);
        do_restart(23'h30, 23'h40, 1'b1);
        chk("abort_req_drop", {8'd0, req, addr}, 32'h30);
        chk("restart_clr_overrun", {31'd0, overrun}, 32'd0);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        cyc();
        chk("late_ack_ignored", {8'd0, req, addr}, 32'h30);

        // Asynchronous reset mid-request, then paused ticks.
        en = 1'b1;
        cyc();
        en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", {8'd0, req, addr}, 32'h0);
        #2 rst = 1'b1;
        cyc();
        play = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en = 1'b1;
            cyc();
            en = 1'b0;
            cyc();
            chk("pause_no_req", {30'd0, req, overrun}, 32'd0);
        end

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
